conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter DW, default 9: pixel width in bits.
REQ-002 Parameter IMG_W, default 256: pixels per image row; legal range 3..65535.
REQ-003 Parameter IMG_H, default 256: rows per image; legal range 3..65535.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: pulse to begin a frame; sampled only in IDLE.
REQ-007 in_valid  input  1: in_data carries a valid pixel.
REQ-008 in_ready  output  1: block accepts a pixel this cycle.
REQ-009 in_data  input  DW: pixel, raster order, row 0 first, column 0 first.
REQ-010 win_valid  output  1: win_data, win_col and win_row hold a valid 3x3 window.
REQ-011 win_ready  input  1: consumer accepts the window this cycle.
REQ-012 win_data  output  9*DW: window; slice [DW*(3r+c) +: DW] = pixel (row win_row+r, col win_col+c), r,c in 0..2.
REQ-013 win_col  output  16: top-left column of the current window.
REQ-014 win_row  output  16: top-left row of the current window.
REQ-015 busy  output  1: high in RUN and FLUSH.
REQ-016 done  output  1: one-cycle pulse at end of frame.

Function
REQ-017 States: IDLE, RUN, FLUSH; transfers: pixel on in_valid&&in_ready, window on win_valid&&win_ready.
REQ-018 IDLE: in_ready=0; start=1 -> RUN with pixel counters x=0, y=0.
REQ-019 RUN: in_ready = !win_valid || win_ready (1 pixel/cycle under no backpressure, same-cycle window hand-off allowed).
REQ-020 Each accepted pixel increments x; at x=IMG_W-1, x wraps to 0 and y increments.
REQ-021 Two line buffers of IMG_W entries hold rows y-1 and y-2; pixel at column x is written after the old column-x entries are read.
REQ-022 A 3x3 shift register advances only on an accepted pixel; no state changes while in_ready=0.
REQ-023 Accepted pixel (x,y) with x>=2 and y>=2 sets win_valid=1 on the next cycle, win_col=x-2, win_row=y-2; other pixels produce no window.
REQ-024 win_data, win_col, win_row stable while win_valid=1 and win_ready=0.
REQ-025 win_valid clears after a window transfer unless a new window loads the same cycle.
REQ-026 Windows per frame exactly (IMG_W-2)*(IMG_H-2), emitted in raster order of top-left position.
REQ-027 Accepting pixel (IMG_W-1, IMG_H-1) -> FLUSH; in_ready=0 in FLUSH.
REQ-028 FLUSH: when the final window transfers (or win_valid=0), done=1 for one cycle and state -> IDLE.
REQ-029 start outside IDLE is ignored; in_valid in IDLE/FLUSH is ignored.
REQ-030 Line buffer contents are not reset; unwritten entries never reach win_data because of REQ-023.

Reset
REQ-031 reset=1 at any time, including mid-frame: state IDLE, x=y=0, in_ready=0, win_valid=0, win_data=0, win_col=0, win_row=0, busy=0, done=0.
REQ-032 After reset release, the next frame behaves identically to a first frame; no partial-frame data appears.

Verification (IMG_W=5, IMG_H=4, DW=9, pixel value = 5y+x)
REQ-033 Start, stream 20 pixels back-to-back, win_ready=1 -> first window one cycle after pixel 12: win_data {0,1,2,5,6,7,10,11,12}, col 0, row 0; 6 windows total; last {7,8,9,12,13,14,17,18,19}, col 2, row 1; done one cycle after last window transfer.
REQ-034 Hold win_ready=0 after first window -> in_ready=0, win_data/win_col/win_row constant; release -> stream resumes, no window lost or duplicated.
REQ-035 Random in_valid gaps and random win_ready -> window sequence and contents identical to REQ-033.
REQ-036 Assert reset after 8 pixels, then start a new frame -> outputs zero during reset; new frame output identical to REQ-033.
REQ-037 Pulse start during RUN and FLUSH -> no effect; second frame after done matches REQ-033.

Source files
------------

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Turns a raster-order pixel stream into a stream of 3x3 neighbourhood
//   windows for convolution. Two line buffers hold the previous two rows. A
//   3x3 shift register holds the three most recent columns. A window is
//   emitted for every top-left position (IMG_W-2)*(IMG_H-2) per frame.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   start      : begin a frame (sampled only when idle)
//   in_valid   : in_data carries a pixel
//   in_ready   : a pixel is accepted this cycle when in_valid is also high
//   in_data    : pixel, raster order
//   win_valid  : win_data / win_col / win_row hold a window
//   win_ready  : consumer accepts the window this cycle
//   win_data   : 3x3 window, slice [DW*(3r+c) +: DW] = pixel (row r, col c)
//   win_col    : top-left column of the window
//   win_row    : top-left row of the window
//   busy       : a frame is in progress (RUN or FLUSH)
//   done       : one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module conv_window_gen #(
    parameter int DW    = 9,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [9*DW-1:0] win_data,
    output logic [15:0]     win_col,
    output logic [15:0]     win_row,
    output logic            busy,
    output logic            done
);

    localparam int AW = $clog2(IMG_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

    logic [1:0]  r_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_win_valid;
    logic [15:0] r_win_col;
    logic [15:0] r_win_row;
    logic        r_done;

    // Window register, indexed [row][col]. Row 0 is the oldest image row and
    // column 2 the most recently accepted column.
    logic [2:0][2:0][DW-1:0] r_win;

    // r_lb1 holds row y-1, r_lb2 holds row y-2, both addressed by column.
    logic [DW-1:0] r_lb1 [IMG_W];
    logic [DW-1:0] r_lb2 [IMG_W];

    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_lb1_q;
    logic [DW-1:0] w_lb2_q;
    logic          w_accept;
    logic          w_win_load;
    logic          w_x_last;
    logic          w_y_last;

    assign in_ready   = (r_state == S_RUN) && (!r_win_valid || win_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_addr     = r_x[AW-1:0];
    assign w_lb1_q    = r_lb1[w_addr];
    assign w_lb2_q    = r_lb2[w_addr];
    assign w_x_last   = (r_x == X_LAST);
    assign w_y_last   = (r_y == Y_LAST);
    // Only positions whose full 3x3 neighbourhood has been written this frame
    // produce a window, so stale line-buffer contents never reach the output.
    assign w_win_load = w_accept && (r_x >= 16'd2) && (r_y >= 16'd2);

    // NOTE: line buffers have no reset. Every entry read into a valid window
    // has already been written earlier in the same frame, so resetting them
    // would cost logic and buy nothing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_addr] <= in_data;
            r_lb2[w_addr] <= w_lb1_q;
        end
    end

    // NOTE: all state below uses non-blocking assignments. Every register
    // therefore samples pre-edge values, and the line-buffer read above sees
    // the old column entry in the same cycle it is overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_win_valid <= 1'b0;
            r_win_col   <= '0;
            r_win_row   <= '0;
            r_win       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb2_q;
                r_win[1][2] <= w_lb1_q;
                r_win[2][2] <= in_data;
            end

            if (w_win_load) begin
                r_win_valid <= 1'b1;
                r_win_col   <= r_x - 16'd2;
                r_win_row   <= r_y - 16'd2;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_x_last) begin
                            r_x <= '0;
                            if (w_y_last) begin
                                r_y     <= '0;
                                r_state <= S_FLUSH;
                            end else begin
                                r_y <= r_y + 16'd1;
                            end
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Last window has gone (or is going this cycle).
                    if (!r_win_valid || win_ready) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The packed [row][col][bit] layout already matches the output slicing.
    assign win_data  = r_win;
    assign win_valid = r_win_valid;
    assign win_col   = r_win_col;
    assign win_row   = r_win_row;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
//   Self-checking bench for conv_window_gen with a 5x4 image, 9-bit pixels and
//   pixel value 5y+x. Expected windows are pushed to a scoreboard queue when
//   the producing pixel is accepted and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

    localparam int DW    = 9;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int N_WIN = (IMG_W - 2) * (IMG_H - 2);

    logic            clk;
    logic            reset;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            win_valid;
    logic            win_ready;
    logic [9*DW-1:0] win_data;
    logic [15:0]     win_col;
    logic [15:0]     win_row;
    logic            busy;
    logic            done;

    conv_window_gen #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_col   (win_col),
        .win_row   (win_row),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [9*DW-1:0] data;
        logic [15:0]     col;
        logic [15:0]     row;
    } win_t;

    typedef struct {
        int gap_max;     // random idle cycles before each pixel (0..gap_max)
        int stall_pct;   // percent of cycles with win_ready low
        int exp_windows; // windows expected in the frame
    } frame_vec_t;

    win_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_win = 0;
    int   cyc = 0;
    int   last_xfer_cyc = -10;
    int   lat_due = -10;
    int   stall_pct = 0;
    bit   hold_low = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9*DW-1:0] exp_win(input int c0, input int r0);
        logic [9*DW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[DW*(3*r+c) +: DW] = DW'(IMG_W * (r0 + r) + (c0 + c));
        return w;
    endfunction

    // Consumer: random backpressure, or held low on request.
    initial begin
        win_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) win_ready = 1'b0;
            else          win_ready = ($urandom_range(99) >= stall_pct);
        end
    end

    // Scoreboard monitor: every cycle a window is presented it must match the
    // oldest outstanding expectation; it retires on transfer.
    always @(negedge clk) begin
        if (!reset && win_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_window: got col %0d row %0d, expected no window", win_col, win_row);
            end else begin
                check("win_data", win_data, q[0].data);
                check("win_col", win_col, q[0].col);
                check("win_row", win_row, q[0].row);
                if (win_ready) begin
                    void'(q.pop_front());
                    n_win++;
                    last_xfer_cyc = cyc;
                end
            end
        end
        if (!reset && cyc == lat_due) check("win_latency", win_valid, 1'b1);
    end

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int first, input int count, input int gap_max);
        for (int i = first; i < first + count; i++) begin
            int  px;
            int  py;
            bit  ok;
            win_t e;
            px = i % IMG_W;
            py = i / IMG_W;
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = DW'(IMG_W * py + px);
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: pixel %0d got in_ready 0, expected 1", i);
            end else if (px >= 2 && py >= 2) begin
                e.data = exp_win(px - 2, py - 2);
                e.col  = 16'(px - 2);
                e.row  = 16'(py - 2);
                q.push_back(e);
                if (stall_pct == 0 && !hold_low) lat_due = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_windows);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got done 0, expected 1");
        end else begin
            check("done_latency", cyc - last_xfer_cyc, 1);
        end
        check("window_count", n_win, exp_windows);
        check("queue_empty", q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("busy_after", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int gap_max, input int exp_windows);
        n_win = 0;
        start_frame();
        drive_pixels(0, IMG_W * IMG_H, gap_max);
        wait_done(exp_windows);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_win_valid"}, win_valid, 1'b0);
        check({tag, "_win_data"},  win_data,  '0);
        check({tag, "_win_col"},   win_col,   16'd0);
        check({tag, "_win_row"},   win_row,   16'd0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
    endtask

    frame_vec_t vecs[5];

    initial begin
        vecs[0] = '{gap_max: 0, stall_pct: 0,  exp_windows: N_WIN};
        vecs[1] = '{gap_max: 3, stall_pct: 0,  exp_windows: N_WIN};
        vecs[2] = '{gap_max: 0, stall_pct: 50, exp_windows: N_WIN};
        vecs[3] = '{gap_max: 2, stall_pct: 40, exp_windows: N_WIN};
        vecs[4] = '{gap_max: 4, stall_pct: 75, exp_windows: N_WIN};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Frames under different input gaps and output backpressure.
        for (int v = 0; v < 5; v++) begin
            stall_pct = vecs[v].stall_pct;
            run_frame(vecs[v].gap_max, vecs[v].exp_windows);
        end

        // Hold off the first window: input must stall and the window must hold.
        stall_pct = 0;
        hold_low  = 1'b1;
        n_win     = 0;
        start_frame();
        fork
            drive_pixels(0, IMG_W * IMG_H, 0);
        join_none
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (win_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("hold_first_window", seen, 1'b1);
            for (int t = 0; t < 8; t++) begin
                @(negedge clk);
                check("hold_in_ready", in_ready, 1'b0);
                check("hold_win_valid", win_valid, 1'b1);
                check("hold_win_data", win_data, exp_win(0, 0));
            end
        end
        hold_low = 1'b0;
        wait_done(N_WIN);

        // Reset in the middle of a frame, then a clean frame.
        n_win = 0;
        start_frame();
        drive_pixels(0, 8, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        q.delete();
        lat_due = -10;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_frame(0, N_WIN);

        // start held high through RUN and FLUSH must not disturb the frame.
        n_win = 0;
        start_frame();
        start = 1'b1;
        drive_pixels(0, IMG_W * IMG_H, 1);
        wait_done(N_WIN);
        run_frame(0, N_WIN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
